// File: rtl/dmem_pkg.sv
// Shared encodings and address checking for the MEM-stage data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_ILLEGAL = 2'b00;
  localparam logic [1:0] SZ_WORD    = 2'b01;
  localparam logic [1:0] SZ_HALF    = 2'b10;
  localparam logic [1:0] SZ_BYTE    = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True when the access is out of range, illegal in size, or misaligned.
  function automatic logic access_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] span,
                                        input logic [1:0]  size);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || (off >= span) || (size == SZ_ILLEGAL) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_unit_load_extend.sv
// Lane select plus sign/zero extension of a raw 32-bit read word.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lane,
  output logic [31:0] result_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c   = word[7:0];
    half_c   = lane[1] ? word[31:16] : word[15:0];
    result_c = word;
    case (lane)
      2'd1:    byte_c = word[15:8];
      2'd2:    byte_c = word[23:16];
      2'd3:    byte_c = word[31:24];
      default: byte_c = word[7:0];
    endcase
    case (size)
      SZ_BYTE: result_c = {{24{sgn & byte_c[7]}}, byte_c};
      SZ_HALF: result_c = {{16{sgn & half_c[15]}}, half_c};
      default: result_c = word;
    endcase
  end

endmodule

// File: rtl/dmem_unit.sv
// Data memory with valid/ready requests, fixed-latency in-order responses,
// fault detection and a zero-fill init sequencer that runs after every reset.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  state_e        state_q, state_d;
  logic [AW-1:0] init_cnt;
  logic          accept_c, fault_c, unused_c;
  logic [31:0]   offset_c, wword_c, ext_c;
  logic [AW-1:0] idx_c;
  logic [3:0]    be_c;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_q;
  logic          s1_valid, s1_load, s1_fault, s1_signed;
  logic [1:0]    s1_size, s1_lane;
  logic          o1_valid, o1_fault;
  logic [31:0]   o1_rdata;

  assign accept_c = req_valid & req_ready;
  assign offset_c = req_addr - BASE_ADDR;
  assign idx_c    = offset_c[AW+1:2];
  assign fault_c  = access_fault(req_addr, BASE_ADDR, SPAN, req_size);
  assign unused_c = ^offset_c[31:AW+2];

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    be_c    = 4'b0000;
    wword_c = req_wdata;
    case (req_size)
      SZ_WORD: be_c = 4'b1111;
      SZ_HALF: begin
        be_c    = offset_c[1] ? 4'b1100 : 4'b0011;
        wword_c = {2{req_wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_c    = 4'(4'b0001 << offset_c[1:0]);
        wword_c = {4{req_wdata[7:0]}};
      end
      default: be_c = 4'b0000;
    endcase
  end

  // Array: init zero-fill, lane-masked stores, synchronous read.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_cnt] <= '0;
    end else if (accept_c && req_we && !fault_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wword_c[8*i +: 8];
      end
    end
    rd_q <= mem[idx_c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == ST_RUN);
      if (state_q == ST_INIT) init_cnt <= init_cnt + AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_cnt == AW'(DEPTH - 1)) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Request attributes travel alongside the RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_load    <= 1'b0;
      s1_fault   <= 1'b0;
      s1_signed  <= 1'b0;
      s1_size    <= SZ_ILLEGAL;
      s1_lane    <= 2'b00;
      fault_addr <= '0;
    end else begin
      s1_valid  <= accept_c;
      s1_load   <= ~req_we;
      s1_fault  <= fault_c;
      s1_signed <= req_signed;
      s1_size   <= req_size;
      s1_lane   <= offset_c[1:0];
      if (accept_c && fault_c) fault_addr <= req_addr;
    end
  end

  load_extend u_load_extend (
    .word     (rd_q),
    .size     (s1_size),
    .sgn      (s1_signed),
    .lane     (s1_lane),
    .result_c (ext_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o1_valid <= 1'b0;
      o1_fault <= 1'b0;
      o1_rdata <= '0;
    end else begin
      o1_valid <= s1_valid;
      o1_fault <= s1_valid & s1_fault;
      o1_rdata <= (s1_valid && s1_load && !s1_fault) ? ext_c : '0;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic        o2_valid, o2_fault;
    logic [31:0] o2_rdata;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        o2_valid <= 1'b0;
        o2_fault <= 1'b0;
        o2_rdata <= '0;
      end else begin
        o2_valid <= o1_valid;
        o2_fault <= o1_fault;
        o2_rdata <= o1_rdata;
      end
    end
    assign rsp_valid = o2_valid;
    assign rsp_fault = o2_fault;
    assign rsp_rdata = o2_rdata;
  end else begin : g_lat1
    assign rsp_valid = o1_valid;
    assign rsp_fault = o1_fault;
    assign rsp_rdata = o1_rdata;
  end

endmodule
